s1423_n90_pattern_ctrl: RTL and testbench
=========================================

Name: s1423_n90_pattern_ctrl

Overview:
- Sequencer that applies test patterns to the combinational s1423 n90 cone and checks the result.
- Serially loads a 30-bit pattern, presents it to the cone as a glitch-free parallel word, waits a configurable settle time, then captures n90.
- Compares n90 against an expected bit and keeps a saturating mismatch count.
- Sits between the pattern source (scan/ATE model) and the cone instance in the reliability test harness.

Parameters:
PAT_W, 30, pattern width; equals the cone input count.
SETTLE, 2, idle cycles between apply and capture (0 allowed).
CNT_W, 16, mismatch counter width.

Ports:
CK  in  1  clock, rising edge.
RST  in  1  synchronous active-high reset.
start  in  1  begin one pattern cycle; sampled only in IDLE.
scan_in  in  1  serial pattern bit, LSB first.
exp_n90  in  1  expected cone response; latched on the accepted start.
clr_cnt  in  1  synchronous clear of err_cnt.
pat_out  out  PAT_W  parallel pattern to cone. Bit order: bit0=G1, G2, G3, G4, G8, G14, G31, G30, G29, G92, G28, G27, G24, G25, G26, G46, G90, G45, G84, G78, G85, G44, G64, G77, G76, G43, G42, G0, G75, bit29=G74.
n90_in  in  1  cone response.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse in the DONE state.
resp  out  1  captured n90.
mismatch  out  1  resp XOR latched exp_n90, from the last capture.
err_cnt  out  CNT_W  saturating mismatch count.

Behaviour:
- Reset (synchronous, RST high at a rising edge) sets:
  - state to IDLE;
  - shift register, pat_out, resp, mismatch, err_cnt, done and the exp latch to 0.
- RST takes priority over every other input, including in the middle of an operation. The pattern is aborted and done is not pulsed.
- FSM states: IDLE, SHIFT, APPLY, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 latches exp_n90 and clears the shift counter; next state is SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - Each edge does shreg <= {scan_in, shreg[PAT_W-1:1]} and increments the counter.
  - After exactly PAT_W edges, the first bit shifted in sits at bit0; next state is APPLY.
  - pat_out does not change during SHIFT.
- APPLY: pat_out <= shreg, lasting one cycle. Next state is SETTLE, or CAPTURE if SETTLE=0.
- SETTLE: stays SETTLE cycles, using a counter reset on entry. Next state is CAPTURE.
- CAPTURE:
  - resp <= n90_in.
  - mismatch <= n90_in ^ exp.
  - err_cnt increments by 1 on a mismatch and saturates at all-ones (no wrap).
  - Next state is DONE.
- DONE: done=1 for this cycle only; next state is IDLE. pat_out, resp and mismatch hold until the next APPLY/CAPTURE.
- Latency: with the start edge at E, done is high in the cycle after edge E+PAT_W+SETTLE+2. For the defaults, done is visible 35 cycles after start is sampled.
- start while busy=1 is ignored and not queued.
- clr_cnt=1 zeroes err_cnt on the next edge in any state.
  - clr_cnt and a CAPTURE increment in the same cycle: the clear wins, leaving err_cnt=0.
- scan_in and exp_n90 are don't-care outside the cycles in which they are sampled.
- Back-to-back operation: start held high gives a new pattern cycle every PAT_W+SETTLE+4 cycles (IDLE is re-entered for one cycle).

Test Plan:
- Reset: RST high for 2 cycles mid-SHIFT -> state IDLE, pat_out=0, err_cnt=0, busy=0, no done pulse.
- Shift order: shift pattern 30'h0000_0001 (first bit 1, then 29 zeros) -> after APPLY, pat_out=30'h0000_0001 (G1=1); done exactly 35 cycles after start.
- Cone check: pattern with G14=0 (bit5=0), exp_n90=1, behavioural cone model attached -> resp=0, mismatch=1, err_cnt=1.
- Cone check: G14=1, G29=1 (bit8), G30=1 (bit7), G31=1 (bit6), all others 0, exp_n90=0 -> n90=NOR(~(G30|G31... ), G30&G31-path...) computed by the model; resp matches the model and mismatch=0.
- Saturation: CNT_W=4, 17 forced mismatches -> err_cnt stops at 4'hF. clr_cnt asserted in a CAPTURE cycle with a mismatch -> err_cnt=0.
- Protocol: start pulsed during SETTLE is ignored (single done). SETTLE=0 build -> done 33 cycles after start. start held high -> done pulses every 36 cycles.

Source files
------------

// File: rtl/s1423_n90_pattern_ctrl.sv
// Pattern sequencer for the s1423 n90 cone: serial load, glitch-free parallel apply,
// settle wait, capture of n90 and a saturating mismatch count.
module s1423_n90_pattern_ctrl #(
   parameter int PAT_W  = 30,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             start,
   input  logic             scan_in,
   input  logic             exp_n90,
   input  logic             clr_cnt,
   output logic [PAT_W-1:0] pat_out,
   input  logic             n90_in,
   output logic             busy,
   output logic             done,
   output logic             resp,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int SH_W     = $clog2(PAT_W + 1);
   localparam int SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_APPLY,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t           state;
   logic [PAT_W-1:0] shreg;
   logic [SH_W-1:0]  shCnt;
   logic [SET_W-1:0] setCnt;
   logic             expLatch;

   assign busy = (state != ST_IDLE);

   // The cone only ever sees shreg through pat_out, which is loaded once in APPLY,
   // so the serial load never ripples onto the cone inputs.
   always_ff @(posedge CK) begin
      if (RST) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         shCnt    <= '0;
         setCnt   <= '0;
         expLatch <= 1'b0;
         pat_out  <= '0;
         resp     <= 1'b0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  expLatch <= exp_n90;
                  shCnt    <= '0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               shreg <= {scan_in, shreg[PAT_W-1:1]};
               shCnt <= shCnt + 1'b1;
               if (shCnt == SH_W'(PAT_W - 1)) begin
                  state <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               pat_out <= shreg;
               setCnt  <= '0;
               state   <= (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
               if (setCnt == SET_W'(SET_LAST)) begin
                  state <= ST_CAPTURE;
               end else begin
                  setCnt <= setCnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               resp     <= n90_in;
               mismatch <= n90_in ^ expLatch;
               if ((n90_in ^ expLatch) && (err_cnt != '1)) begin
                  err_cnt <= err_cnt + 1'b1;
               end
               done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
         // A clear overrides any increment made in the same cycle.
         if (clr_cnt) begin
            err_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_s1423_n90_pattern_ctrl.sv
// Self-checking bench: default build plus a SETTLE=0 / CNT_W=4 build, each driving a
// stand-in n90 cone model from its own pat_out.
module tb_s1423_n90_pattern_ctrl;

   localparam int PAT_W = 30;

   logic        CK;
   logic        RST;
   logic        startS [2];
   logic        scanS  [2];
   logic        expS   [2];
   logic        clrS   [2];
   logic [29:0] patS   [2];
   logic        busyS  [2];
   logic        doneS  [2];
   logic        respS  [2];
   logic        misS   [2];
   logic        n90A, n90B;
   logic [15:0] errA;
   logic [3:0]  errB;

   int total = 0;
   int bad   = 0;

   int          modelErr [2];
   int          errMax   [2];
   int          settleOf [2];
   logic [29:0] lastPat  [2];

   typedef struct {
      logic [29:0] pat;
      logic        expv;
      logic        wantResp;
      logic        wantMis;
   } vec_t;

   vec_t tbl [6];

   // Simplified stand-in for the n90 cone: G14 gated off when G29, G30 and G31 are all high.
   function automatic logic cone(input logic [29:0] p);
      return p[5] & ~(p[6] & p[7] & p[8]);
   endfunction

   function automatic int errOf(input int sel);
      return (sel == 0) ? int'(errA) : int'(errB);
   endfunction

   assign n90A = cone(patS[0]);
   assign n90B = cone(patS[1]);

   s1423_n90_pattern_ctrl #(.PAT_W(30), .SETTLE(2), .CNT_W(16)) dutA (
      .CK(CK), .RST(RST), .start(startS[0]), .scan_in(scanS[0]), .exp_n90(expS[0]),
      .clr_cnt(clrS[0]), .pat_out(patS[0]), .n90_in(n90A), .busy(busyS[0]),
      .done(doneS[0]), .resp(respS[0]), .mismatch(misS[0]), .err_cnt(errA)
   );

   s1423_n90_pattern_ctrl #(.PAT_W(30), .SETTLE(0), .CNT_W(4)) dutB (
      .CK(CK), .RST(RST), .start(startS[1]), .scan_in(scanS[1]), .exp_n90(expS[1]),
      .clr_cnt(clrS[1]), .pat_out(patS[1]), .n90_in(n90B), .busy(busyS[1]),
      .done(doneS[1]), .resp(respS[1]), .mismatch(misS[1]), .err_cnt(errB)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic checkOutput(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   // One full pattern cycle; latency counted in falling edges from the one where start rises.
   task automatic applyStimulus(input int sel, input logic [29:0] pat, input logic expv,
                                input logic wantResp, input logic wantMis,
                                input bit clrAtCap, input string tag);
      int cnt;
      int lat;
      int capCnt;
      bit wantClr;
      lat    = PAT_W + settleOf[sel] + 3;
      capCnt = PAT_W + settleOf[sel] + 2;
      startS[sel] = 1'b1;
      expS[sel]   = expv;
      @(negedge CK);
      cnt = 1;
      startS[sel] = 1'b0;
      expS[sel]   = 1'($urandom);
      for (int i = 0; i < PAT_W; i++) begin
         scanS[sel] = pat[i];
         if (i == 15) checkOutput({tag, "_hold_during_shift"}, int'(patS[sel]), int'(lastPat[sel]));
         @(negedge CK);
         cnt++;
      end
      scanS[sel] = 1'($urandom);
      while (doneS[sel] !== 1'b1 && cnt < lat + 20) begin
         clrS[sel] = (clrAtCap && cnt == capCnt);
         @(negedge CK);
         cnt++;
      end
      clrS[sel] = 1'b0;
      wantClr = clrAtCap;
      lastPat[sel] = pat;
      if (wantClr) modelErr[sel] = 0;
      else if (wantMis && modelErr[sel] < errMax[sel]) modelErr[sel]++;
      checkOutput({tag, "_latency"}, cnt, lat);
      checkOutput({tag, "_pat_out"}, int'(patS[sel]), int'(pat));
      checkOutput({tag, "_resp"}, int'(respS[sel]), int'(wantResp));
      checkOutput({tag, "_mismatch"}, int'(misS[sel]), int'(wantMis));
      checkOutput({tag, "_err_cnt"}, errOf(sel), modelErr[sel]);
      @(negedge CK);
      checkOutput({tag, "_done_one_cycle"}, int'(doneS[sel]), 0);
   endtask

   initial begin
      int cnt;
      int dones;
      int tms[$];
      logic [29:0] rp;
      logic re;

      tbl[0] = '{30'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{30'h3FFF_FFDF, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{30'h0000_01E0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{30'h0000_0020, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{30'h0000_00A0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{30'h2AAA_AAAA, 1'b1, 1'b1, 1'b0};

      errMax[0] = 65535; errMax[1] = 15;
      settleOf[0] = 2;   settleOf[1] = 0;
      for (int s = 0; s < 2; s++) begin
         startS[s] = 1'b0; scanS[s] = 1'b0; expS[s] = 1'b0; clrS[s] = 1'b0;
         modelErr[s] = 0; lastPat[s] = '0;
      end

      RST = 1'b1;
      repeat (2) @(negedge CK);
      for (int s = 0; s < 2; s++) begin
         checkOutput("reset_busy", int'(busyS[s]), 0);
         checkOutput("reset_done", int'(doneS[s]), 0);
         checkOutput("reset_pat_out", int'(patS[s]), 0);
         checkOutput("reset_err_cnt", errOf(s), 0);
      end
      RST = 1'b0;
      @(negedge CK);

      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, tbl[k].pat, tbl[k].expv, tbl[k].wantResp, tbl[k].wantMis, 1'b0,
                       $sformatf("vec%0d", k));
      end

      // Reset in the middle of SHIFT aborts the pattern without a done pulse.
      startS[0] = 1'b1;
      @(negedge CK);
      startS[0] = 1'b0;
      scanS[0]  = 1'b1;
      repeat (10) @(negedge CK);
      RST = 1'b1;
      repeat (2) @(negedge CK);
      RST = 1'b0;
      for (int s = 0; s < 2; s++) begin modelErr[s] = 0; lastPat[s] = '0; end
      checkOutput("midshift_reset_busy", int'(busyS[0]), 0);
      checkOutput("midshift_reset_pat_out", int'(patS[0]), 0);
      checkOutput("midshift_reset_err_cnt", errOf(0), 0);
      checkOutput("midshift_reset_resp", int'(respS[0]), 0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CK);
         if (doneS[0]) dones++;
      end
      checkOutput("midshift_reset_no_done", dones, 0);

      for (int k = 0; k < 20; k++) begin
         rp = 30'($urandom);
         re = 1'($urandom);
         applyStimulus(0, rp, re, cone(rp), cone(rp) ^ re, 1'b0, $sformatf("rand%0d", k));
      end

      // start pulsed during SETTLE must not start a second pattern.
      startS[0] = 1'b1; expS[0] = 1'b0; scanS[0] = 1'b0;
      @(negedge CK);
      cnt = 1; dones = 0;
      while (cnt < 120) begin
         startS[0] = (cnt == 32);
         @(negedge CK);
         cnt++;
         if (doneS[0]) dones++;
      end
      startS[0] = 1'b0;
      lastPat[0] = '0;
      checkOutput("start_in_settle_single_done", dones, 1);
      checkOutput("start_in_settle_err_cnt", errOf(0), modelErr[0]);

      // start held high: one pattern every PAT_W+SETTLE+4 cycles.
      startS[0] = 1'b1; expS[0] = 1'b0; scanS[0] = 1'b0;
      cnt = 0;
      while (tms.size() < 3 && cnt < 200) begin
         @(negedge CK);
         cnt++;
         if (doneS[0]) tms.push_back(cnt);
      end
      startS[0] = 1'b0;
      checkOutput("b2b_pulse_count", tms.size(), 3);
      if (tms.size() == 3) begin
         checkOutput("b2b_period1", tms[1] - tms[0], 36);
         checkOutput("b2b_period2", tms[2] - tms[1], 36);
      end
      cnt = 0;
      while (busyS[0] && cnt < 60) begin
         @(negedge CK);
         cnt++;
      end
      @(negedge CK);
      checkOutput("b2b_idle_after", int'(busyS[0]), 0);

      applyStimulus(1, 30'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, "s0_shift");
      for (int k = 0; k < 17; k++) begin
         applyStimulus(1, 30'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("sat%0d", k));
      end
      checkOutput("sat_final_err_cnt", errOf(1), 15);
      applyStimulus(1, 30'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b1, "clr_at_capture");
      applyStimulus(1, 30'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, "after_clr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
